inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
Instruction-fetch front end between the memory controller's instruction port and the core's decode/execute stage. It keeps a fetch PC, issues word fetch requests to the memory controller, and buffers returned instructions with their PCs in a small in-order queue. It hands them to the core through a valid/ready handshake. A redirect from the core (jump/branch) flushes the queue and restarts fetching at the new PC, and any in-flight fetch response is dropped.

Parameters:
QUEUE_DEPTH, 4, number of buffered instructions; must be a power of two, at least 2.
RESET_PC, 32'h0, first fetch address after reset.

Ports:
clk_in  input  1  system clock.
rst_in  input  1  reset; synchronous, active-high.
rdy_in  input  1  global enable; when low, all state is frozen.
mem_valid  output  1  fetch request to the memory controller's instruction port.
mem_addr  output  32  fetch word address; low 2 bits are always 0.
mem_ready  input  1  one-cycle pulse: the outstanding fetch has completed and mem_data is valid.
mem_data  input  32  fetched instruction word.
redirect_valid  input  1  one-cycle pulse from the core: restart fetch.
redirect_pc  input  32  restart address; low 2 bits are ignored (forced to 0).
out_valid  output  1  queue head is valid.
out_inst  output  32  instruction at the queue head.
out_pc  output  32  PC of the queue head.
out_ready  input  1  core consumes the head when out_valid && out_ready.

Behaviour:
- Single clock. All state updates occur on posedge clk_in.
- Priority at each edge: rst_in, then !rdy_in (hold everything; ignore mem_ready, redirect_valid and out_ready), then normal operation.
- Reset values:
  - mem_valid=0, mem_addr=RESET_PC, fetch_pc=RESET_PC.
  - Queue empty, so out_valid=0; out_inst=0 and out_pc=0 are don't-care while out_valid=0.
  - discard=0, outstanding=0.
- Request contract:
  - At most one fetch is outstanding.
  - Once mem_valid rises, mem_valid and mem_addr stay stable until the edge where mem_ready=1.
  - On that edge, the block may immediately re-assert the request with a new mem_addr (back-to-back, no bubble).
- Issue condition, evaluated with next-state values: no request is outstanding after this edge, and (queue count + outstanding) < QUEUE_DEPTH. When issuing, mem_addr<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32), mem_valid<=1.
- Response handling: mem_ready && !discard pushes {mem_data, mem_addr} into the queue tail. Space is always guaranteed by the issue credit, so a push never overflows.
- Pop: out_valid && out_ready removes the head.
  - Push and pop in the same cycle leave the count unchanged.
  - Out_valid and out_inst/out_pc come from the head, combinationally from the queue registers. The first instruction is visible the cycle after its mem_ready.
- Redirect (redirect_valid=1):
  - Queue flushed (count=0). A pop or push in the same cycle is nullified.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - If a request is outstanding and mem_ready=0 this cycle: the request is held unchanged and discard<=1. When its mem_ready arrives, the data is dropped, discard clears, and the next request is issued from fetch_pc on that edge.
  - If mem_ready=1 in the redirect cycle: the response is dropped and a new request to the redirect target issues on that edge.
  - If a second redirect arrives while discard=1: only fetch_pc is updated.
- States (two-bit encoding): IDLE (no request), WAIT (request outstanding, keep data), DROP (request outstanding, discard data).
  - IDLE→WAIT on issue.
  - WAIT→WAIT or IDLE on mem_ready, depending on credit.
  - WAIT→DROP on redirect without mem_ready.
  - DROP→WAIT or IDLE on mem_ready.
- Full queue: mem_valid stays low until a pop frees credit. The request issues on the same edge as the pop.
- Wrap-around: fetch_pc+4 wraps 32'hFFFFFFFC→32'h0. Queue pointers wrap modulo QUEUE_DEPTH.

Decomposition:
- Shared package:
  - XLEN=32.
  - INST_WIDTH=32.
  - Default RESET_PC.
  - Fetch-state enum {IDLE, WAIT, DROP}.
  - Fetch-entry struct {inst[31:0], pc[31:0]}.
- One sub-module: flush_fifo, a synchronous FIFO of fetch entries with push/pop/flush/count. Flush wins over push/pop. It has no rdy_in; the parent gates enables.
- FSM, credit logic and PC live in inst_fetch_queue.

Test Plan:
1. Stream: reset, out_ready=1, memory answers 2 cycles after each request with word=addr^32'hA5A5_0000 -> out_pc sequence 0,4,8,12 with matching out_inst. At most one request is outstanding at any time.
2. Backpressure: out_ready=0, 1-cycle memory -> exactly 4 entries accepted (pc 0..12). mem_valid is 0 with mem_addr 0x10 not requested. Pulse out_ready for 1 cycle -> pc 0 popped and a request for 0x10 issues on the same edge.
3. Redirect mid-fetch: redirect_pc=0x100 while the fetch of 0x8 is outstanding -> queue empty next cycle. The 0x8 data never appears. The next mem_addr is 0x100 and the first out_pc is 0x100.
4. Triple coincidence: redirect_valid, mem_ready and out_valid&&out_ready in the same cycle, redirect_pc=0x203 -> next cycle count=0. mem_valid=1 with mem_addr=0x200. No stale entry is ever output.
5. Freeze: hold rdy_in=0 for 5 cycles while toggling out_ready/redirect_valid -> all outputs constant. Resume continues the sequence exactly where it stopped.
6. Wrap and reset: redirect to 0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x00000000. Assert rst_in with a request outstanding -> next cycle mem_valid=0, out_valid=0, and the first new request is at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch front end.
package inst_fetch_queue_pkg;

    localparam int XLEN       = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // IDLE: no request, WAIT: request outstanding (keep data), DROP: outstanding (discard data)
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DROP = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [XLEN-1:0]       pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_flush_fifo.sv
// In-order FIFO of fetch entries; flush has priority over push and pop.
module flush_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         push_in,
    input  fetch_entry_t push_entry_in,
    input  logic         pop_in,
    input  logic         flush_in,
    output fetch_entry_t head_out,
    output logic [CW-1:0] count_out
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;

    assign pop_ok    = pop_in && (count_q != '0);
    assign head_out  = mem_q[rd_ptr_q];
    assign count_out = count_q;

    // Next storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_in) begin
                mem_d[wr_ptr_q] = push_entry_in;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push_in) - CW'(pop_ok);
        end
    end

    // Register FIFO state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: fetch PC, single-outstanding request, redirect handling.
//
// state | meaning
// IDLE  | no fetch request outstanding
// WAIT  | request outstanding, response will be queued
// DROP  | request outstanding, response will be discarded (redirected meanwhile)
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int              QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    output logic                  mem_valid,
    output logic [XLEN-1:0]       mem_addr,
    input  logic                  mem_ready,
    input  logic [INST_WIDTH-1:0] mem_data,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  out_valid,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [XLEN-1:0]       out_pc,
    input  logic                  out_ready
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            mem_valid_q, mem_valid_d;

    logic            fifo_push, fifo_pop, fifo_flush;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   count_next;
    logic [XLEN-1:0] target_pc;
    logic            busy_after;

    assign push_entry = '{inst: mem_data, pc: mem_addr_q};

    flush_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .push_in       (fifo_push),
        .push_entry_in (push_entry),
        .pop_in        (fifo_pop),
        .flush_in      (fifo_flush),
        .head_out      (fifo_head),
        .count_out     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_inst  = fifo_head.inst;
    assign out_pc    = fifo_head.pc;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;

    // Next fetch state; issue credit is judged on the post-edge queue count.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        mem_addr_d  = mem_addr_q;
        mem_valid_d = mem_valid_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        count_next  = fifo_count;
        target_pc   = fetch_pc_q;
        busy_after  = 1'b0;
        if (rdy_in) begin
            target_pc = redirect_valid ? word_align(redirect_pc) : fetch_pc_q;
            if (redirect_valid) begin
                fifo_flush = 1'b1;
                count_next = '0;
            end else begin
                fifo_push  = (state_q == WAIT) && mem_ready;
                fifo_pop   = out_valid && out_ready;
                count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
            end
            busy_after = (state_q != IDLE) && !mem_ready;
            fetch_pc_d = target_pc;
            if (busy_after) begin
                state_d = (redirect_valid || state_q == DROP) ? DROP : WAIT;
            end else if (count_next < CW'(QUEUE_DEPTH)) begin
                state_d     = WAIT;
                mem_addr_d  = target_pc;
                fetch_pc_d  = target_pc + 32'd4;
                mem_valid_d = 1'b1;
            end else begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        end
    end

    // Register FSM, fetch PC and request outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            mem_addr_q  <= RESET_PC;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            mem_addr_q  <= mem_addr_d;
            mem_valid_q <= mem_valid_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, mem_ready, redirect_valid, out_ready;
    logic [31:0] mem_data, redirect_pc;
    logic        mem_valid, out_valid;
    logic [31:0] mem_addr, out_inst, out_pc;

    inst_fetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_valid      (mem_valid),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of {inst, pc}, plus fetch pointer and request bookkeeping.
    logic [63:0] mq[$];
    bit          m_out, m_disc;
    logic [31:0] m_addr, m_fpc;
    int          lat;

    int k_rdy, k_ready, k_redir, k_lat_lo, k_lat_hi;
    bit k_tri, k_wrap;

    task automatic model_reset();
        mq.delete();
        m_out  = 0;
        m_disc = 0;
        m_addr = RPC;
        m_fpc  = RPC;
        lat    = 0;
    endtask

    task automatic model_step();
        bit resp;
        if (!rdy_in) return;
        resp = m_out && mem_ready;
        if (redirect_valid) begin
            mq.delete();
            m_fpc = {redirect_pc[31:2], 2'b00};
            if (resp) begin
                m_out  = 0;
                m_disc = 0;
            end else if (m_out) begin
                m_disc = 1;
            end
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (resp) begin
                if (!m_disc) mq.push_back({mem_data, m_addr});
                m_out  = 0;
                m_disc = 0;
            end
        end
        if (!m_out && mq.size() < DEPTH) begin
            m_addr = m_fpc;
            m_fpc  = m_fpc + 32'd4;
            m_out  = 1;
            lat    = $urandom_range(k_lat_lo, k_lat_hi);
        end
    endtask

    task automatic compare();
        logic [63:0] e;
        check("mem_valid", 32'(mem_valid), 32'(m_out));
        if (m_out) check("mem_addr", mem_addr, m_addr);
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            e = mq[0];
            check("out_pc", out_pc, e[31:0]);
            check("out_inst", out_inst, e[63:32]);
        end
    endtask

    task automatic cycle(input bit do_rst);
        int sel;
        @(negedge clk_in);
        compare();
        rst_in    = do_rst;
        rdy_in    = ($urandom_range(0, 99) < k_rdy);
        out_ready = ($urandom_range(0, 99) < k_ready);
        mem_ready = 1'b0;
        if (m_out) begin
            if (lat == 0) mem_ready = 1'b1;
            else lat--;
        end
        mem_data       = mem_ready ? (m_addr ^ 32'hA5A5_0000) : $urandom;
        redirect_valid = ($urandom_range(0, 99) < k_redir);
        sel            = $urandom_range(0, 2);
        if (k_wrap && sel == 0)      redirect_pc = 32'hFFFF_FFFC;
        else if (k_wrap && sel == 1) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else                         redirect_pc = $urandom;
        if (k_tri && mem_ready && mq.size() > 0) begin
            rdy_in         = 1'b1;
            out_ready      = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_0203;
        end
        if (do_rst) model_reset();
        else        model_step();
    endtask

    task automatic phase(input int n, input int rdy_pct, input int ready_pct, input int redir_pct,
                         input int lat_lo, input int lat_hi, input bit tri_on, input bit wrap_on);
        k_rdy = rdy_pct; k_ready = ready_pct; k_redir = redir_pct;
        k_lat_lo = lat_lo; k_lat_hi = lat_hi; k_tri = tri_on; k_wrap = wrap_on;
        repeat (n) cycle(1'b0);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; mem_ready = 1'b0; mem_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        k_rdy = 100; k_ready = 0; k_redir = 0; k_lat_lo = 0; k_lat_hi = 0; k_tri = 0; k_wrap = 0;
        repeat (2) @(posedge clk_in);
        model_reset();
        #1;
        check("rst_mem_valid", 32'(mem_valid), 32'h0);
        check("rst_mem_addr", mem_addr, RPC);
        check("rst_out_valid", 32'(out_valid), 32'h0);

        // Backpressure from reset: queue fills with pc 0..12, 0x10 held back.
        phase(15, 100, 0, 0, 0, 0, 0, 0);
        @(posedge clk_in); #1;
        check("bp_mem_valid", 32'(mem_valid), 32'h0);
        check("bp_head_pc", out_pc, 32'h0);
        phase(1, 100, 100, 0, 0, 0, 0, 0);
        @(posedge clk_in); #1;
        check("bp_reissue_valid", 32'(mem_valid), 32'h1);
        check("bp_reissue_addr", mem_addr, 32'h10);
        check("bp_new_head", out_pc, 32'h4);

        // Streaming with 2-cycle memory, then mixed random traffic.
        phase(60, 100, 100, 0, 2, 2, 0, 0);
        phase(400, 100, 60, 5, 0, 3, 0, 0);
        // Freeze window followed by resume.
        phase(5, 0, 50, 50, 0, 2, 0, 0);
        phase(100, 100, 70, 3, 0, 2, 0, 0);
        // Redirect coinciding with response and pop.
        phase(300, 100, 80, 0, 0, 2, 1, 0);
        // Wrap-around targets near the top of the address space.
        phase(300, 90, 70, 8, 0, 3, 0, 1);

        // Reset with a request in flight.
        phase(3, 100, 50, 0, 3, 3, 0, 0);
        cycle(1'b1);
        @(posedge clk_in); #1;
        check("rst2_mem_valid", 32'(mem_valid), 32'h0);
        check("rst2_out_valid", 32'(out_valid), 32'h0);
        phase(1, 100, 50, 0, 1, 1, 0, 0);
        @(posedge clk_in); #1;
        check("rst2_first_addr", mem_addr, RPC);

        phase(800, 85, 60, 6, 0, 3, 0, 1);
        @(negedge clk_in);
        compare();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
